// File: rtl/tail_light_sequencer_pkg.sv
// Shared mode encodings and width helpers for the tail-light sequencer.
package tail_light_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  localparam int DEFAULT_LAMPS    = 3;
  localparam int DEFAULT_TICK_DIV = 4;

  function automatic int step_width(input int lamps);
    return $clog2(lamps + 1);
  endfunction

  function automatic int count_width(input int tick_div);
    return $clog2(tick_div);
  endfunction

endpackage

// File: rtl/tail_light_sequencer_blink_tick_gen.sv
// Animation-step divider: one tick every TICK_DIV cycles, realigned by restart.
module blink_tick_gen
  import tail_light_sequencer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = count_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // A restart suppresses the tick so a mode entry always gets a full first step.
  assign tick = (count == LAST) && !restart;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Registered tail-light sequencer: turn fill sweeps, hazard flashing, brake overlay.
module tail_light_sequencer
  import tail_light_sequencer_pkg::*;
#(
  parameter int LAMPS    = DEFAULT_LAMPS,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps,
  output logic [1:0]       state
);

  localparam int SW = step_width(LAMPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);

  mode_t            cur_mode, req_mode, nxt_mode;
  logic [SW-1:0]    step, nxt_step;
  logic             phase, nxt_phase;
  logic             mode_change, tick;
  logic [LAMPS-1:0] fill, brake_mask, nxt_left, nxt_right;

  assign state = cur_mode;

  always_comb begin
    req_mode = IDLE;
    if (hazard || (left && right)) req_mode = HAZARD;
    else if (left)                 req_mode = LEFT;
    else if (right)                req_mode = RIGHT;
  end

  assign mode_change = (req_mode != cur_mode);

  blink_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (mode_change),
    .tick    (tick)
  );

  // Lamps are derived from the next-state values so they change on the same edge as state.
  always_comb begin
    nxt_mode  = cur_mode;
    nxt_step  = step;
    nxt_phase = phase;
    if (mode_change) begin
      nxt_mode  = req_mode;
      nxt_step  = (req_mode == LEFT || req_mode == RIGHT) ? SW'(1) : '0;
      nxt_phase = (req_mode == HAZARD);
    end else begin
      case (cur_mode)
        LEFT, RIGHT: if (tick) nxt_step = (step == LAST_STEP) ? '0 : step + 1'b1;
        HAZARD:      if (tick) nxt_phase = ~phase;
        default: begin
          nxt_step  = '0;
          nxt_phase = 1'b0;
        end
      endcase
    end

    for (int i = 0; i < LAMPS; i++) fill[i] = (SW'(i) < nxt_step);
    brake_mask = brake ? '1 : '0;

    nxt_left  = '0;
    nxt_right = '0;
    case (nxt_mode)
      IDLE: begin
        nxt_left  = brake_mask;
        nxt_right = brake_mask;
      end
      LEFT: begin
        nxt_left  = fill;
        nxt_right = brake_mask;
      end
      RIGHT: begin
        nxt_left  = brake_mask;
        nxt_right = fill;
      end
      default: begin
        nxt_left  = nxt_phase ? '1 : '0;
        nxt_right = nxt_phase ? '1 : '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_mode    <= IDLE;
      step        <= '0;
      phase       <= 1'b0;
      left_lamps  <= '0;
      right_lamps <= '0;
    end else begin
      cur_mode    <= nxt_mode;
      step        <= nxt_step;
      phase       <= nxt_phase;
      left_lamps  <= nxt_left;
      right_lamps <= nxt_right;
    end
  end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Self-checking bench: directed scenarios plus random requests against a cycle-count model.
module tb_tail_light_sequencer;

  localparam int LAMPS    = 3;
  localparam int TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic [LAMPS-1:0] left_lamps, right_lamps;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  // Model: current mode plus cycles elapsed since it was entered.
  int m_mode = 0;
  int m_n    = 0;

  tail_light_sequencer #(.LAMPS(LAMPS), .TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .left        (left),
    .right       (right),
    .hazard      (hazard),
    .brake       (brake),
    .left_lamps  (left_lamps),
    .right_lamps (right_lamps),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [LAMPS-1:0] fill_mask(input int s);
    logic [31:0] tmp;
    tmp = (32'd1 << s) - 32'd1;
    return tmp[LAMPS-1:0];
  endfunction

  task automatic apply_stimulus(input logic r, input logic l, input logic rt, input logic h, input logic b);
    int req;
    logic [LAMPS-1:0] ones, exp_l, exp_r;
    reset = r; left = l; right = rt; hazard = h; brake = b;
    @(posedge clk);
    if (r) begin
      m_mode = 0;
      m_n    = 0;
    end else begin
      req = (h || (l && rt)) ? 3 : (l ? 1 : (rt ? 2 : 0));
      if (req != m_mode) begin
        m_mode = req;
        m_n    = 0;
      end else begin
        m_n++;
      end
    end
    ones  = '1;
    exp_l = '0;
    exp_r = '0;
    if (!r) begin
      case (m_mode)
        0: begin exp_l = b ? ones : '0; exp_r = b ? ones : '0; end
        1: begin exp_l = fill_mask((m_n / TICK_DIV + 1) % (LAMPS + 1)); exp_r = b ? ones : '0; end
        2: begin exp_r = fill_mask((m_n / TICK_DIV + 1) % (LAMPS + 1)); exp_l = b ? ones : '0; end
        default: begin
          exp_l = ((m_n / TICK_DIV) % 2 == 0) ? ones : '0;
          exp_r = exp_l;
        end
      endcase
    end
    #1;
    check_output("state", 32'(state), 32'(m_mode));
    check_output("left_lamps", 32'(left_lamps), 32'(exp_l));
    check_output("right_lamps", 32'(right_lamps), 32'(exp_r));
  endtask

  initial begin
    logic [4:0] vec;
    int hold;

    // Reset held with conflicting requests, then hazard.
    repeat (3) apply_stimulus(1, 1, 0, 1, 1);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("hazard_entry_state", 32'(state), 32'd3);
    check_output("hazard_entry_lamps", 32'({left_lamps, right_lamps}), 32'h3f);

    // Left sweep from idle, two full periods.
    apply_stimulus(0, 0, 0, 0, 0);
    repeat (2 * (LAMPS + 1) * TICK_DIV) apply_stimulus(0, 1, 0, 0, 0);

    // Both turn requests act as hazard; brake ignored.
    repeat (10) apply_stimulus(0, 1, 1, 0, 0);
    repeat (10) apply_stimulus(0, 1, 1, 0, 1);

    // Right sweep with brake, then drop right.
    apply_stimulus(0, 0, 0, 0, 0);
    repeat (20) apply_stimulus(0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("brake_idle_lamps", 32'({left_lamps, right_lamps}), 32'h3f);

    // Switch left to right mid-sweep; counter restarts.
    apply_stimulus(0, 0, 0, 0, 0);
    repeat (TICK_DIV + 2) apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("switch_right_lamps", 32'(right_lamps), 32'h1);
    repeat (TICK_DIV) apply_stimulus(0, 0, 1, 0, 0);

    // Reset mid-hazard with phase on.
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 1, 0);
    check_output("mid_reset_lamps", 32'({left_lamps, right_lamps}), 32'h0);
    apply_stimulus(0, 0, 0, 1, 0);

    // Random request vectors held for random spans.
    for (int k = 0; k < 60; k++) begin
      vec  = 5'($urandom);
      hold = $urandom_range(1, 24);
      for (int c = 0; c < hold; c++)
        apply_stimulus(($urandom_range(0, 40) == 0), vec[0], vec[1], vec[2] & vec[3], vec[4]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
